// File: rtl/mvm_operand_sequencer.sv
// Operand loader and result streamer around a combinational N x N matrix-vector multiplier.
// Optional build macro MVM_SEQ_MATRIX_HOLD_EN adds keep_a, which lets a frame reload only B.
module mvm_operand_sequencer #(
  parameter int WIDTH = 32,
  parameter int N     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [N*N*WIDTH-1:0]   a_flat,
  output logic [N*WIDTH-1:0]     b_flat,
  input  logic [N*WIDTH-1:0]     c_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
`ifdef MVM_SEQ_MATRIX_HOLD_EN
  input  logic                   keep_a,
`endif
  output logic                   busy
);

  localparam int TOTAL  = N * N + N;
  localparam int IDX_W  = $clog2(TOTAL);
  localparam int OIDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TOTAL - 1);
  localparam logic [OIDX_W-1:0] OIDX_LAST = OIDX_W'(N - 1);

  typedef enum logic [1:0] {LOAD, SETTLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, widx;
  logic [OIDX_W-1:0]   oidx;
  logic                ready_en;
  logic                in_fire, out_fire, last_in;
  logic [WIDTH-1:0]    ops    [TOTAL];
  logic [WIDTH-1:0]    result [N];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A keep_a frame starts writing at the first B slot, so the rest of the frame is a normal B load.
  always_comb begin
    widx = idx;
`ifdef MVM_SEQ_MATRIX_HOLD_EN
    if (idx == '0 && keep_a) widx = IDX_W'(N * N);
`endif
  end

  assign last_in = (widx == IDX_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this combinational block from inferring latches.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && last_in)   state_nxt = SETTLE;
      SETTLE:                            state_nxt = SEND;
      SEND:    if (out_fire && out_last) state_nxt = LOAD;
      default:                           state_nxt = LOAD;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = ready_en && (state == LOAD);
    out_valid = (state == SEND);
    out_last  = (state == SEND) && (oidx == OIDX_LAST);
    out_data  = (state == SEND) ? result[oidx] : '0;
    busy      = (state != LOAD);
  end

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Operand/result storage and the two indices.
  // NOTE: the operand and result arrays are cleared by reset because a_flat/b_flat must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      oidx <= '0;
      for (int i = 0; i < TOTAL; i++) ops[i] <= '0;
      for (int i = 0; i < N; i++)     result[i] <= '0;
    end else begin
      if (in_fire) begin
        ops[widx] <= in_data;
        idx       <= last_in ? '0 : widx + 1'b1;
      end
      if (state == SETTLE) begin
        for (int i = 0; i < N; i++) result[i] <= c_flat[i*WIDTH +: WIDTH];
        oidx <= '0;
      end else if (out_fire) begin
        oidx <= out_last ? '0 : oidx + 1'b1;
      end
    end
  end

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int i = 0; i < N * N; i++) a_flat[i*WIDTH +: WIDTH] = ops[i];
    for (int i = 0; i < N; i++)     b_flat[i*WIDTH +: WIDTH] = ops[N*N + i];
  end

endmodule

// File: tb/tb_mvm_operand_sequencer.sv
// Directed bench for mvm_operand_sequencer; a small combinational multiplier model closes the loop.
// Covers reset, latency, backpressure, gapped input, mid-frame reset, pass-through and optional matrix hold.
module tb_mvm_operand_sequencer;

  localparam int WIDTH = 32;
  localparam int N     = 3;
  localparam int AW    = N * N * WIDTH;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [AW-1:0]     a_flat;
  logic [N*WIDTH-1:0] b_flat;
  logic [N*WIDTH-1:0] c_flat;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              keep_a;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out_hs = 0;
  int t0, hs0;

  logic [WIDTH-1:0] stim [12];

  mvm_operand_sequencer #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .c_flat    (c_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef MVM_SEQ_MATRIX_HOLD_EN
    .keep_a    (keep_a),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) n_out_hs <= n_out_hs + 1;
  end

  // Multiplier model, wrapping mod 2^WIDTH.
  always_comb begin
    logic [WIDTH-1:0] acc;
    c_flat = '0;
    for (int r = 0; r < N; r++) begin
      acc = '0;
      for (int c = 0; c < N; c++)
        acc = acc + a_flat[(r*N+c)*WIDTH +: WIDTH] * b_flat[c*WIDTH +: WIDTH];
      c_flat[r*WIDTH +: WIDTH] = acc;
    end
  end

  task automatic check(input string tag, input logic [AW-1:0] observed, input logic [AW-1:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [AW-1:0] pack_a();
    logic [AW-1:0] v;
    v = '0;
    for (int i = 0; i < N * N; i++) v[i*WIDTH +: WIDTH] = stim[i];
    return v;
  endfunction

  function automatic logic [AW-1:0] pack_b(input int base);
    logic [AW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = stim[base + i];
    return v;
  endfunction

  task automatic load_basic();
    stim = '{32'h1, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h3, 32'hFFFF_FFFF,
             32'h1, 32'h2, 32'h1, 32'h3, 32'hFFFF_FFFF, 32'h4};
  endtask

  task automatic load_ident();
    stim = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0,
             32'h0, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic feed_word(input logic [WIDTH-1:0] d, input logic k);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", in_ready, 1);
    in_data  = d;
    keep_a   = k;
    in_valid = 1'b1;
    @(negedge clk);
    keep_a   = 1'b0;
  endtask

  task automatic feed_frame(input int cnt, input int first, input logic [11:0] gap, input logic keep);
    for (int i = 0; i < cnt; i++) begin
      if (gap[i]) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      feed_word(stim[first + i], keep && (i == 0));
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                         input logic [WIDTH-1:0] e2, input bit stall);
    logic [WIDTH-1:0] exp_w [3];
    int guard;
    exp_w[0] = e0;
    exp_w[1] = e1;
    exp_w[2] = e2;
    for (int i = 0; i < 3; i++) begin
      guard = 0;
      while (!out_valid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("out_valid_wait", out_valid, 1);
      if (stall) begin
        out_ready = 1'b0;
        repeat (4) begin
          check("stall_data", out_data, exp_w[i]);
          check("stall_last", out_last, (i == 2));
          check("stall_in_ready", in_ready, 0);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check("out_data", out_data, exp_w[i]);
      check("out_last", out_last, (i == 2));
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    keep_a    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_a_flat", a_flat, 0);
    check("rst_b_flat", b_flat, 0);
    rst_n = 1'b1;
    #1 check("release_in_ready", in_ready, 0);
    @(negedge clk);
    check("first_edge_in_ready", in_ready, 1);

    // Basic frame at full rate
    load_basic();
    t0  = cyc;
    hs0 = n_out_hs;
    feed_frame(12, 0, 12'h000, 1'b0);
    check("full_rate_cycles", cyc - t0, 12);
    check("settle_out_valid", out_valid, 0);
    check("settle_busy", busy, 1);
    check("settle_in_ready", in_ready, 0);
    check("basic_a_flat", a_flat, pack_a());
    check("basic_b_flat", b_flat, pack_b(9));
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    collect(32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0005, 1'b0);
    check("basic_hs_count", n_out_hs - hs0, 3);
    check("basic_in_ready_back", in_ready, 1);
    check("basic_out_valid_low", out_valid, 0);
    check("basic_busy_low", busy, 0);

    // Backpressure
    hs0 = n_out_hs;
    feed_frame(12, 0, 12'h000, 1'b0);
    collect(32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0005, 1'b1);
    check("bp_hs_count", n_out_hs - hs0, 3);
    check("bp_in_ready_back", in_ready, 1);

    // Gapped input, then in_valid held with junk while busy
    load_ident();
    feed_frame(12, 0, 12'h000, 1'b0);
    collect(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0);
    load_basic();
    feed_frame(12, 0, 12'b0101_0011_0010, 1'b0);
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("gap_send_a_flat", a_flat, pack_a());
    check("gap_send_b_flat", b_flat, pack_b(9));
    in_valid = 1'b0;
    collect(32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0005, 1'b0);

    // Reset mid-load after 7 words
    load_ident();
    feed_frame(7, 0, 12'h000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midload_a_flat", a_flat, 0);
    check("midload_b_flat", b_flat, 0);
    check("midload_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midload_in_ready_back", in_ready, 1);

    // Reset during SEND after one result word
    load_basic();
    feed_frame(12, 0, 12'h000, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    check("midsend_first", out_data, 32'hFFFF_FFFB);
    @(negedge clk);
    out_ready = 1'b0;
    check("midsend_second", out_data, 32'hFFFF_FFF9);
    rst_n = 1'b0;
    #1;
    check("midsend_out_valid", out_valid, 0);
    check("midsend_out_data", out_data, 0);
    check("midsend_out_last", out_last, 0);
    check("midsend_busy", busy, 0);
    check("midsend_a_flat", a_flat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity / overflow pass-through after reset
    load_ident();
    feed_frame(12, 0, 12'h000, 1'b0);
    collect(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0);

`ifdef MVM_SEQ_MATRIX_HOLD_EN
    // Matrix hold: reload only B with 1,1,1
    load_basic();
    feed_frame(12, 0, 12'h000, 1'b0);
    collect(32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0005, 1'b0);
    stim[9]  = 32'h1;
    stim[10] = 32'h1;
    stim[11] = 32'h1;
    feed_frame(3, 9, 12'h000, 1'b1);
    check("hold_a_flat", a_flat, pack_a());
    check("hold_b_flat", b_flat, pack_b(9));
    collect(32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0004, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
